cmp_pipe: RTL and testbench

Parametrised, pipelined magnitude comparator. It supersedes the fixed 8-bit combinational unsigned greater-or-equal comparator, which is built from an invert stage and a carry-chain adder.
- The A + ~B + 1 carry chain is split into CHUNK-bit slices, with one slice per pipeline stage.
- Supports signed or unsigned operands and six selectable relations.
- Uses a valid/ready handshake on both sides.
- Sits between datapath producers and control logic that needs registered compare results at full clock rate.

---
 rtl/cmp_pipe.sv | 131 +++++++++++++
 tb/tb_cmp_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined signed/unsigned magnitude comparator.
// Skewed A + ~B + 1 carry chain, CHUNK bits resolved per stage.
module cmp_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MODE,
    input  logic             SIGNED,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             O,
    output logic             O_EQ,
    output logic             O_GE
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    logic             advance;
    logic [WIDTH-1:0] a_ent;
    logic [WIDTH-1:0] b_ent;

    assign advance = !O_VALID || O_READY;
    assign I_READY = advance;

    // MSB flip maps two's-complement order onto unsigned order
    assign a_ent = {A[WIDTH-1] ^ SIGNED, A[WIDTH-2:0]};
    assign b_ent = ~{B[WIDTH-1] ^ SIGNED, B[WIDTH-2:0]};

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO  = k * CHUNK;
        localparam int SRC = WIDTH - LO;
        localparam int SW  = (SRC < CHUNK) ? SRC : CHUNK;
        localparam int REM = SRC - SW;

        logic [SRC-1:0] a_src;
        logic [SRC-1:0] b_src;
        logic           cin;
        logic           eq_in;
        logic           v_in;
        logic [2:0]     m_in;
        logic [SW:0]    sum;
        logic           eq_sl;
        logic           carry_q;
        logic           eq_q;
        logic           v_q;
        logic [2:0]     m_q;

        if (k == 0) begin : g_src
            assign a_src = a_ent;
            assign b_src = b_ent;
            assign cin   = 1'b1;
            assign eq_in = 1'b1;
            assign v_in  = I_VALID;
            assign m_in  = MODE;
        end else begin : g_src
            assign a_src = stg[k-1].g_up.a_q;
            assign b_src = stg[k-1].g_up.b_q;
            assign cin   = stg[k-1].carry_q;
            assign eq_in = stg[k-1].eq_q;
            assign v_in  = stg[k-1].v_q;
            assign m_in  = stg[k-1].m_q;
        end

        assign sum = {1'b0, a_src[SW-1:0]}
                   + {1'b0, b_src[SW-1:0]}
                   + {{SW{1'b0}}, cin};
        assign eq_sl = (a_src[SW-1:0] == ~b_src[SW-1:0]);

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                carry_q <= 1'b0;
                eq_q    <= 1'b0;
                v_q     <= 1'b0;
                m_q     <= 3'd0;
            end else if (advance) begin
                carry_q <= sum[SW];
                eq_q    <= eq_in & eq_sl;
                v_q     <= v_in;
                m_q     <= m_in;
            end
        end

        if (REM > 0) begin : g_up
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[SRC-1:SW];
                    b_q <= b_src[SRC-1:SW];
                end
            end
        end
    end

    logic       f_ge;
    logic       f_eq;
    logic [2:0] f_m;
    logic       rel;

    assign f_ge    = stg[STAGES-1].carry_q;
    assign f_eq    = stg[STAGES-1].eq_q;
    assign f_m     = stg[STAGES-1].m_q;
    assign O_VALID = stg[STAGES-1].v_q;
    assign O_GE    = f_ge;
    assign O_EQ    = f_eq;
    assign O       = rel;

    always_comb begin
        rel = 1'b0;
        unique case (1'b1)
            (f_m == 3'd0): rel = f_eq;
            (f_m == 3'd1): rel = !f_eq;
            (f_m == 3'd2): rel = !f_ge;
            (f_m == 3'd3): rel = !f_ge | f_eq;
            (f_m == 3'd4): rel = f_ge & !f_eq;
            (f_m == 3'd5): rel = f_ge;
            default:       rel = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: directed checks of cmp_pipe at 8/4 and 10/4.
// Expected values are hand-computed per vector.
module tb_cmp_pipe;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv8, ir8, ov8, or8, o8, eq8, ge8, sg8;
    logic [7:0] a8, b8;
    logic [2:0] m8;

    logic       iv10, ir10, ov10, or10, o10, eq10, ge10, sg10;
    logic [9:0] a10, b10;
    logic [2:0] m10;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(8), .CHUNK(4)) u8 (
        .CLK(clk), .RESETN(rst_n),
        .I_VALID(iv8), .I_READY(ir8),
        .A(a8), .B(b8), .MODE(m8), .SIGNED(sg8),
        .O_VALID(ov8), .O_READY(or8),
        .O(o8), .O_EQ(eq8), .O_GE(ge8)
    );

    cmp_pipe #(.WIDTH(10), .CHUNK(4)) u10 (
        .CLK(clk), .RESETN(rst_n),
        .I_VALID(iv10), .I_READY(ir10),
        .A(a10), .B(b10), .MODE(m10), .SIGNED(sg10),
        .O_VALID(ov10), .O_READY(or10),
        .O(o10), .O_EQ(eq10), .O_GE(ge10)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] m, input logic s);
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
        m8  = m;
        sg8 = s;
    endtask

    task automatic run8(input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] m, input logic s,
                        input logic eo, input logic eeq, input logic ege);
        drive8(a, b, m, s);
        step;
        iv8 = 1'b0;
        chk({tag, "_lat1"}, 32'(ov8), 32'd0);
        step;
        chk({tag, "_v"},  32'(ov8), 32'd1);
        chk({tag, "_o"},  32'(o8),  32'(eo));
        chk({tag, "_eq"}, 32'(eq8), 32'(eeq));
        chk({tag, "_ge"}, 32'(ge8), 32'(ege));
    endtask

    task automatic run10(input string tag,
                         input logic [9:0] a, input logic [9:0] b,
                         input logic [2:0] m, input logic s,
                         input logic eo);
        iv10 = 1'b1;
        a10  = a;
        b10  = b;
        m10  = m;
        sg10 = s;
        step;
        iv10 = 1'b0;
        chk({tag, "_lat1"}, 32'(ov10), 32'd0);
        step;
        chk({tag, "_lat2"}, 32'(ov10), 32'd0);
        step;
        chk({tag, "_v"}, 32'(ov10), 32'd1);
        chk({tag, "_o"}, 32'(o10),  32'(eo));
    endtask

    logic [6:0] eq_sweep;

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; sg8 = 1'b0; or8 = 1'b1;
        iv10 = 1'b0; a10 = '0; b10 = '0; m10 = '0; sg10 = 1'b0; or10 = 1'b1;
        #2;
        chk("rst_ov8", 32'(ov8), 32'd0);
        chk("rst_o8",  32'(o8),  32'd0);
        chk("rst_eq8", 32'(eq8), 32'd0);
        chk("rst_ge8", 32'(ge8), 32'd0);
        chk("rst_ir8", 32'(ir8), 32'd1);
        chk("rst_ov10", 32'(ov10), 32'd0);
        step;
        step;
        rst_n = 1'b1;
        step;

        run8("t1_uns", 8'h80, 8'h7F, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        run8("t1_sgn", 8'h80, 8'h7F, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        eq_sweep = 7'b0101001;
        for (int m = 0; m < 7; m++) begin
            run8($sformatf("t2_m%0d", m), 8'h5A, 8'h5A, 3'(m), 1'b0,
                 eq_sweep[m], 1'b1, 1'b1);
        end

        run8("t3_gt", 8'h10, 8'h0F, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        run8("t3_lt", 8'h0F, 8'h10, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        run8("t3_ge", 8'hF0, 8'hEF, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        step;

        or8 = 1'b1;
        drive8(8'h01, 8'h02, 3'd5, 1'b0);
        step;
        drive8(8'h03, 8'h03, 3'd5, 1'b0);
        step;
        chk("bp_r0_v", 32'(ov8), 32'd1);
        chk("bp_r0_o", 32'(o8),  32'd0);
        or8 = 1'b0;
        drive8(8'h09, 8'h04, 3'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_hold%0d_ir", i), 32'(ir8), 32'd0);
            chk($sformatf("bp_hold%0d_v", i),  32'(ov8), 32'd1);
            chk($sformatf("bp_hold%0d_o", i),  32'(o8),  32'd0);
            chk($sformatf("bp_hold%0d_eq", i), 32'(eq8), 32'd0);
            step;
        end
        or8 = 1'b1;
        step;
        chk("bp_r1_v",  32'(ov8), 32'd1);
        chk("bp_r1_o",  32'(o8),  32'd1);
        chk("bp_r1_eq", 32'(eq8), 32'd1);
        drive8(8'hFF, 8'h00, 3'd5, 1'b0);
        step;
        iv8 = 1'b0;
        chk("bp_r2_v",  32'(ov8), 32'd1);
        chk("bp_r2_o",  32'(o8),  32'd1);
        chk("bp_r2_eq", 32'(eq8), 32'd0);
        step;
        chk("bp_r3_v",  32'(ov8), 32'd1);
        chk("bp_r3_o",  32'(o8),  32'd1);
        chk("bp_r3_eq", 32'(eq8), 32'd0);
        step;
        chk("bp_drain", 32'(ov8), 32'd0);

        drive8(8'h05, 8'h03, 3'd5, 1'b0);
        step;
        drive8(8'h07, 8'h02, 3'd5, 1'b0);
        step;
        iv8 = 1'b0;
        chk("rm_pre_v", 32'(ov8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_async_v",  32'(ov8), 32'd0);
        chk("rm_async_o",  32'(o8),  32'd0);
        chk("rm_async_ge", 32'(ge8), 32'd0);
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk($sformatf("rm_quiet%0d", i), 32'(ov8), 32'd0);
        end
        run8("rm_after", 8'h02, 8'h09, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        run10("t6_sgn", 10'h3FF, 10'h000, 3'd2, 1'b1, 1'b1);
        run10("t6_uns", 10'h3FF, 10'h000, 3'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
